// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 SPI loopback receiver.
package ssd1306_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam logic [BYTE_W-1:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [BYTE_W-1:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [BYTE_W-1:0] CMD_COL_ADDR    = 8'h21;

    typedef struct packed {
        logic              dc;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/sync_cell.sv
// N-stage synchroniser for one asynchronous input; resets to a chosen idle level.
module sync_cell #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ssd1306_spi_sink.sv
// Oversampling receive end of the 4-wire SSD1306 SPI link: rebuilds {D/C, byte}
// pairs and queues them in a small FIFO behind a valid/ready port.
module ssd1306_spi_sink
    import ssd1306_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_in,
    input  logic              spi_csn_in,
    input  logic              spi_dc_in,
    input  logic              spi_mosi_in,
    output logic [BYTE_W-1:0] rx_data_out,
    output logic              rx_dc_out,
    output logic              rx_valid_out,
    input  logic              rx_ready_in,
    output logic              overflow_out,
    output logic              frame_err_out,
    output logic              busy_out,
    input  logic              clear_in
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic sclk_s, csn_s, dc_s, mosi_s;

    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi_sclk_in), .q_o(sclk_s));
    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst_n(rst_n), .d_i(spi_csn_in), .q_o(csn_s));
    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
        .clk(clk), .rst_n(rst_n), .d_i(spi_dc_in), .q_o(dc_s));
    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(spi_mosi_in), .q_o(mosi_s));

    logic              sclk_prev_q, rise_q, mosi_q, dc_q, csn_q;
    logic [2:0]        cnt_q;
    logic [BYTE_W-1:0] shift_q;
    logic              push_q;
    rx_entry_t         push_entry_q;
    logic              overflow_q, frame_err_q;
    rx_entry_t         mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;

    logic csn_rise, frame_err_set, overflow_set;
    logic empty, full, pop, push_ok;

    assign csn_rise      = csn_s & ~csn_q;
    assign frame_err_set = csn_rise & (cnt_q != 3'd0);

    // Edge pulse, MOSI, D/C and CSn are registered together so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q  <= 1'b0;
            rise_q       <= 1'b0;
            mosi_q       <= 1'b0;
            dc_q         <= 1'b0;
            csn_q        <= 1'b1;
            cnt_q        <= 3'd0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            rise_q      <= sclk_s & ~sclk_prev_q;
            mosi_q      <= mosi_s;
            dc_q        <= dc_s;
            csn_q       <= csn_s;
            push_q      <= 1'b0;
            if (csn_rise) begin
                cnt_q   <= 3'd0;
                shift_q <= '0;
            end else if (rise_q && !csn_q) begin
                shift_q <= {shift_q[BYTE_W-2:0], mosi_q};
                cnt_q   <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    push_q       <= 1'b1;
                    push_entry_q <= '{dc: dc_q, data: {shift_q[BYTE_W-2:0], mosi_q}};
                end
            end
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop          = ~empty & rx_ready_in;
    assign push_ok      = push_q & (~full | pop);
    assign overflow_set = push_q & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_q;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // A set in the same cycle as clear_in wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_set | (overflow_q & ~clear_in);
            frame_err_q <= frame_err_set | (frame_err_q & ~clear_in);
        end
    end

    assign rx_data_out   = mem_q[rd_ptr_q[PTR_W-1:0]].data;
    assign rx_dc_out     = mem_q[rd_ptr_q[PTR_W-1:0]].dc;
    assign rx_valid_out  = ~empty;
    assign overflow_out  = overflow_q;
    assign frame_err_out = frame_err_q;
    assign busy_out      = ~csn_s;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Self-checking bench for ssd1306_spi_sink: SPI master model plus a {dc,byte} scoreboard.
module tb_ssd1306_spi_sink;
    import ssd1306_pkg::*;

    localparam int S    = 2;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0, csn = 1'b1, dc = 1'b0, mosi = 1'b0;
    logic       ready = 1'b0, clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, overflow, frame_err, busy;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    ssd1306_spi_sink #(.FIFO_DEPTH(4), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk_in(sclk), .spi_csn_in(csn), .spi_dc_in(dc), .spi_mosi_in(mosi),
        .rx_data_out(rx_data), .rx_dc_out(rx_dc), .rx_valid_out(rx_valid),
        .rx_ready_in(ready), .overflow_out(overflow), .frame_err_out(frame_err),
        .busy_out(busy), .clear_in(clear));

    always #5 clk = ~clk;

    // Scoreboard monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rx_valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got dc=%0b data=%02h, expected nothing",
                         rx_dc, rx_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rx_dc, rx_data} !== e) begin
                    failures++;
                    $display("FAIL pop_data: got dc=%0b data=%02h, expected dc=%0b data=%02h",
                             rx_dc, rx_data, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        sclk = 1'b0;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
        sclk = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic d, input logic [7:0] v);
        dc = d;
        send_bits(v, 8);
    endtask

    task automatic begin_frame();
        csn = 1'b0;
        tick(HALF);
    endtask

    task automatic end_frame();
        tick(2);
        csn = 1'b1;
        tick(S + 4);
    endtask

    task automatic wait_drain();
        int cyc;
        ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            tick(1);
            cyc++;
        end
        ready = 1'b0;
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d entries still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: rx_valid=%0b, required 0", rx_valid);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({rx_data, rx_dc, rx_valid, overflow, frame_err, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: data=%02h dc=%0b v=%0b ovf=%0b ferr=%0b busy=%0b, required all 0",
                     rx_data, rx_dc, rx_valid, overflow, frame_err, busy);
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: valid=%0b busy=%0b, required 0 0", rx_valid, busy);
        end
    endtask

    task automatic test_latency();
        int lat;
        logic [7:0] v;
        v = CMD_DISPLAY_OFF;
        begin_frame();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_low_csn: busy=%0b, required 1", busy);
        end
        dc = DC_CMD;
        exp_q.push_back({DC_CMD, v});
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        mosi = v[0];
        sclk = 1'b0;
        tick(HALF);
        sclk = 1'b1;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (rx_valid && lat < 0) lat = k;
        end
        checks++;
        if (lat != S + 2) begin
            failures++;
            $display("FAIL latency: valid after %0d cycles, required %0d", lat, S + 2);
        end
        checks++;
        if ({rx_dc, rx_data} !== {DC_CMD, CMD_DISPLAY_OFF}) begin
            failures++;
            $display("FAIL latency_head: dc=%0b data=%02h, required 0 ae", rx_dc, rx_data);
        end
        #1;
        sclk = 1'b0;
        tick(1);
        end_frame();
        wait_drain();
    endtask

    task automatic test_overflow();
        logic [7:0] cmds [3];
        cmds[0] = CMD_COL_ADDR;
        cmds[1] = 8'h00;
        cmds[2] = 8'h7F;
        ready = 1'b0;
        begin_frame();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({DC_CMD, cmds[i]});
            send_byte(DC_CMD, cmds[i]);
        end
        exp_q.push_back({DC_DATA, 8'hFF});
        send_byte(DC_DATA, 8'hFF);
        tick(S + 4);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_at_four: overflow=%0b, required 0", overflow);
        end
        send_byte(DC_DATA, 8'h55);
        tick(S + 4);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_fifth: overflow=%0b, required 1", overflow);
        end
        end_frame();
        wait_drain();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: overflow=%0b, required 0", overflow);
        end
    endtask

    task automatic test_frame_err();
        begin_frame();
        dc = DC_DATA;
        send_bits(8'hB7, 5);
        end_frame();
        checks++;
        if ({frame_err, rx_valid} !== 2'b10) begin
            failures++;
            $display("FAIL ferr_partial: frame_err=%0b valid=%0b, required 1 0", frame_err, rx_valid);
        end
        begin_frame();
        exp_q.push_back({DC_DATA, 8'h3C});
        send_byte(DC_DATA, 8'h3C);
        end_frame();
        wait_drain();
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL ferr_sticky: frame_err=%0b, required 1", frame_err);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_clear: frame_err=%0b, required 0", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        v = 8'h81;
        ready = 1'b0;
        begin_frame();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({DC_DATA, 8'(8'h10 * (i + 1))});
            send_byte(DC_DATA, 8'(8'h10 * (i + 1)));
        end
        tick(S + 4);
        dc = DC_CMD;
        exp_q.push_back({DC_CMD, v});
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        mosi = v[0];
        sclk = 1'b0;
        tick(HALF);
        sclk = 1'b1;
        repeat (S + 2) @(posedge clk);
        #2;
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(HALF);
        sclk = 1'b0;
        tick(1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop_ovf: overflow=%0b, required 0", overflow);
        end
        checks++;
        if (exp_q.size() != 4) begin
            failures++;
            $display("FAIL full_pushpop_pop: %0d expected entries left, required 4", exp_q.size());
        end
        end_frame();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        begin_frame();
        send_byte(DC_DATA, 8'h11);
        tick(S + 4);
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_precond: valid=%0b, required 1", rx_valid);
        end
        dc = DC_DATA;
        send_bits(8'hA5, 4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_dc, rx_valid, overflow, frame_err, busy} !== 13'd0) begin
            failures++;
            $display("FAIL rst_async: data=%02h dc=%0b v=%0b ovf=%0b ferr=%0b busy=%0b, required all 0",
                     rx_data, rx_dc, rx_valid, overflow, frame_err, busy);
        end
        csn = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        begin_frame();
        exp_q.push_back({DC_DATA, 8'hA5});
        send_byte(DC_DATA, 8'hA5);
        end_frame();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_ferr: frame_err=%0b, required 0", frame_err);
        end
        wait_drain();
    endtask

    task automatic test_idle_sclk();
        csn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            tick(HALF);
        end
        tick(S + 4);
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL idle_sclk: valid=%0b busy=%0b, required 0 0", rx_valid, busy);
        end
        begin_frame();
        exp_q.push_back({DC_DATA, 8'h96});
        send_byte(DC_DATA, 8'h96);
        end_frame();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL idle_cnt: frame_err=%0b, required 0", frame_err);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_idle_sclk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
